// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register. Redirects come from the branch unit; stall and
// flush come from the hazard unit.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        br_reg,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_offset,
    input  logic [63:0] br_reg_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] id_pc,
    output logic [63:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [63:0] pc_plus4;
    logic [63:0] br_target;
    logic [63:0] id_pc_d;
    logic [63:0] id_pc_plus4_d;
    logic [31:0] id_instr_d;
    logic        id_valid_d;

    // The PC is the fetch address directly; no input reaches it combinationally.
    assign imem_addr = pc_q;

    // Sequential increment and redirect target. Register targets are forced to
    // word alignment; the PC-relative offset arrives already scaled to bytes.
    always_comb begin
        pc_plus4  = pc_q + 64'd4;
        br_target = br_reg ? (br_reg_target & ~64'h3) : (br_pc + br_offset);
    end

    // Next-state selection: a taken branch beats stall, stall holds everything.
    always_comb begin
        pc_d          = pc_q;
        id_pc_d       = id_pc;
        id_pc_plus4_d = id_pc_plus4;
        id_instr_d    = id_instr;
        id_valid_d    = id_valid;
        if (br_taken) begin
            pc_d          = br_target;
            id_pc_d       = 64'h0;
            id_pc_plus4_d = 64'h0;
            id_instr_d    = 32'h0;
            id_valid_d    = 1'b0;
        end else if (!stall) begin
            pc_d          = pc_plus4;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_instr_d    = imem_instr;
            id_valid_d    = 1'b1;
        end
    end

    // PC and IF/ID state; reset takes effect immediately and drops any pending redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            id_pc       <= 64'h0;
            id_pc_plus4 <= 64'h0;
            id_instr    <= 32'h0;
            id_valid    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            id_pc       <= id_pc_d;
            id_pc_plus4 <= id_pc_plus4_d;
            id_instr    <= id_instr_d;
            id_valid    <= id_valid_d;
        end
    end

endmodule
